// File: rtl/serial_reg_loader_pkg.sv
// Shared definitions for the serial loader and the 8x8 register bank it feeds.
package reg_pkg;

    // Default geometry of the register bank (8 registers of 8 bits)
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_ADDR_W    = 3;
    localparam int DEF_PARITY_EN = 1;

    // Loader FSM states
    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        PAR,
        COMMIT
    } state_t;

    // Total bits on the wire for one frame: start + address + data + optional parity
    function automatic int frame_bits(input int addr_w, input int data_w, input int parity_en);
        return 1 + addr_w + data_w + parity_en;
    endfunction

    localparam int FRAME_BITS = 1 + DEF_ADDR_W + DEF_DATA_W + DEF_PARITY_EN;

    // Bit counter width: enough to count the longer of the two fields, plus one
    function automatic int cnt_width(input int addr_w, input int data_w);
        return $clog2((addr_w > data_w) ? addr_w : data_w) + 1;
    endfunction

endpackage

// File: rtl/serial_reg_loader_if.sv
// Serial input pins plus register-bank write port of the loader.
interface serial_reg_loader_if
    import reg_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              data;
    logic              bit_valid;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              frame_err;

    // Stimulus side: drives the serial line, observes the write port
    modport master (
        output data, bit_valid,
        input  wr_en, wr_addr, wr_data, busy, frame_err
    );

    // Loader side: receives the serial line, drives the write port
    modport slave (
        input  data, bit_valid,
        output wr_en, wr_addr, wr_data, busy, frame_err
    );
endinterface

// File: rtl/serial_reg_loader_shift_in_reg.sv
// MSB-first shift register. The output is the look-ahead contents, i.e. the
// word with this cycle's bit already folded in when en is high, so the loader
// can capture a field on the same edge that accepts its last bit.
module shift_in_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         din,
    output logic [W-1:0] q_next
);
    logic [W-1:0] q;

    generate
        if (W == 1) begin : g_single
            // One-bit field: the new bit simply replaces the old one
            always_comb begin
                q_next = en ? din : q;
            end
        end else begin : g_multi
            // Shift toward the MSB, new bit enters at the LSB
            always_comb begin
                q_next = en ? {q[W-2:0], din} : q;
            end
        end
    endgenerate

    // Storage, cleared by the asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q <= '0;
        else      q <= q_next;
    end
endmodule

// File: rtl/serial_reg_loader.sv
// Serial front-end for the register bank: deserializes start/address/data/
// parity frames and issues a single-cycle write to the bank.
module serial_reg_loader
    import reg_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int PARITY_EN = DEF_PARITY_EN
) (
    input  logic               clk,
    input  logic               rst,
    serial_reg_loader_if.slave bus
);
    localparam int CNT_W = cnt_width(ADDR_W, DATA_W);

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              par_acc, par_next;
    logic              par_fail;
    logic              addr_en, data_en;
    logic [ADDR_W-1:0] addr_nx;
    logic [DATA_W-1:0] data_nx;
    logic              wr_en_q, busy_q, frame_err_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;

    assign addr_en = (state == ADDR) && bus.bit_valid;
    assign data_en = (state == DATA) && bus.bit_valid;

    shift_in_reg #(.W(ADDR_W)) u_addr_sr (
        .clk    (clk),
        .rst    (rst),
        .en     (addr_en),
        .din    (bus.data),
        .q_next (addr_nx)
    );

    shift_in_reg #(.W(DATA_W)) u_data_sr (
        .clk    (clk),
        .rst    (rst),
        .en     (data_en),
        .din    (bus.data),
        .q_next (data_nx)
    );

    // Next-state, bit counter and running parity; nothing moves without bit_valid except COMMIT
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        par_next   = par_acc;
        par_fail   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.bit_valid && bus.data) begin
                    state_next = ADDR;
                    cnt_next   = '0;
                    par_next   = 1'b0;
                end
            end
            ADDR: begin
                if (bus.bit_valid) begin
                    par_next = par_acc ^ bus.data;
                    if (cnt == CNT_W'(ADDR_W - 1)) begin
                        state_next = DATA;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
            DATA: begin
                if (bus.bit_valid) begin
                    par_next = par_acc ^ bus.data;
                    if (cnt == CNT_W'(DATA_W - 1)) begin
                        state_next = (PARITY_EN != 0) ? PAR : COMMIT;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
            PAR: begin
                if (bus.bit_valid) begin
                    cnt_next = '0;
                    par_next = par_acc ^ bus.data;
                    if (par_acc ^ bus.data) begin
                        par_fail   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = COMMIT;
                    end
                end
            end
            COMMIT: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // FSM state, counter and parity accumulator registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            par_acc <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            par_acc <= par_next;
        end
    end

    // Registered outputs; the write word is captured on the edge that enters COMMIT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            wr_en_q     <= (state_next == COMMIT);
            busy_q      <= (state_next != IDLE);
            frame_err_q <= par_fail;
            if (state_next == COMMIT) begin
                wr_addr_q <= addr_nx;
                wr_data_q <= data_nx;
            end
        end
    end

    assign bus.wr_en     = wr_en_q;
    assign bus.busy      = busy_q;
    assign bus.frame_err = frame_err_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
endmodule

// File: tb/tb_serial_reg_loader.sv
// Scoreboard bench for serial_reg_loader: one parity-checking instance and
// one parity-free instance, random frames against a frame-level model.
module tb_serial_reg_loader;
    localparam int AW = 3;
    localparam int DW = 8;

    typedef struct {
        bit             is_err;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  data;
        int unsigned    cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    exp_t          exp_p[$];
    exp_t          exp_n[$];
    logic [AW-1:0] last_addr [2];
    logic [DW-1:0] last_data [2];
    bit            prev_wr [2];

    serial_reg_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus_p ();
    serial_reg_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus_n ();

    serial_reg_loader #(.DATA_W(DW), .ADDR_W(AW), .PARITY_EN(1)) dut_p (
        .clk (clk),
        .rst (rst),
        .bus (bus_p)
    );

    serial_reg_loader #(.DATA_W(DW), .ADDR_W(AW), .PARITY_EN(0)) dut_n (
        .clk (clk),
        .rst (rst),
        .bus (bus_n)
    );

    // Free-running clock and edge counter used to time expected writes
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Drive one cycle of the serial line on the chosen instance (0 = parity, 1 = no parity)
    task automatic drive_cycle(input int sel, input logic v, input logic d);
        if (sel == 0) begin
            bus_p.bit_valid = v;
            bus_p.data      = d;
        end else begin
            bus_n.bit_valid = v;
            bus_n.data      = d;
        end
        @(negedge clk);
    endtask

    // Send one complete frame and record the expected outcome in the scoreboard
    task automatic apply_stimulus(input int sel, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                  input bit par_bit, input bit gapped);
        bit   bits[$];
        bit   odd;
        bit   is_err;
        exp_t e;
        odd    = ($countones({addr, data}) % 2) == 1;
        is_err = (sel == 0) && (par_bit != odd);
        bits.push_back(1'b1);
        for (int i = AW - 1; i >= 0; i--) bits.push_back(addr[i]);
        for (int i = DW - 1; i >= 0; i--) bits.push_back(data[i]);
        if (sel == 0) bits.push_back(par_bit);
        repeat ($urandom_range(0, 2)) drive_cycle(sel, 1'b1, 1'b0);
        for (int i = 0; i < bits.size(); i++) begin
            if (gapped) repeat ($urandom_range(0, 2)) drive_cycle(sel, 1'b0, 1'($urandom_range(0, 1)));
            if (i == bits.size() - 1) begin
                e.is_err = is_err;
                e.addr   = addr;
                e.data   = data;
                e.cyc    = cyc + 1;
                if (sel == 0) exp_p.push_back(e);
                else          exp_n.push_back(e);
            end
            drive_cycle(sel, 1'b1, bits[i]);
        end
        if (!is_err && $urandom_range(0, 1) == 1) drive_cycle(sel, 1'b1, 1'b1);
        drive_cycle(sel, 1'b0, 1'b0);
        repeat ($urandom_range(0, 1)) drive_cycle(sel, 1'b0, 1'b0);
    endtask

    // Compare whatever the DUT presents against the head of its scoreboard queue
    task automatic monitor_step(input int sel, input logic wr_en, input logic fe, input logic busy,
                                input logic [AW-1:0] addr, input logic [DW-1:0] data);
        exp_t e;
        int   n;
        if (!rst) begin
            last_addr[sel] = '0;
            last_data[sel] = '0;
            prev_wr[sel]   = 1'b0;
            return;
        end
        if (prev_wr[sel]) check_output("busy_drop_after_wr", 32'(busy), 32'd0);
        prev_wr[sel] = wr_en;
        if (wr_en || fe) begin
            check_output("wr_err_exclusive", 32'(wr_en & fe), 32'd0);
            n = (sel == 0) ? exp_p.size() : exp_n.size();
            if (n == 0) begin
                check_output("unexpected_wr_en", 32'(wr_en), 32'd0);
                check_output("unexpected_frame_err", 32'(fe), 32'd0);
            end else begin
                e = (sel == 0) ? exp_p.pop_front() : exp_n.pop_front();
                check_output("event_is_err", 32'(fe), 32'(e.is_err));
                check_output("event_is_wr", 32'(wr_en), 32'(!e.is_err));
                check_output("event_cycle", 32'(cyc), 32'(e.cyc));
                if (e.is_err) begin
                    check_output("addr_held_on_err", 32'(addr), 32'(last_addr[sel]));
                    check_output("data_held_on_err", 32'(data), 32'(last_data[sel]));
                end else begin
                    check_output("wr_addr", 32'(addr), 32'(e.addr));
                    check_output("wr_data", 32'(data), 32'(e.data));
                    check_output("busy_during_wr", 32'(busy), 32'd1);
                    last_addr[sel] = e.addr;
                    last_data[sel] = e.data;
                end
            end
        end
    endtask

    // Monitors sample on the falling edge, away from the active edge
    always @(negedge clk) monitor_step(0, bus_p.wr_en, bus_p.frame_err, bus_p.busy, bus_p.wr_addr, bus_p.wr_data);
    always @(negedge clk) monitor_step(1, bus_n.wr_en, bus_n.frame_err, bus_n.busy, bus_n.wr_addr, bus_n.wr_data);

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_p_wr_en"},     32'(bus_p.wr_en), 32'd0);
        check_output({tag, "_p_wr_addr"},   32'(bus_p.wr_addr), 32'd0);
        check_output({tag, "_p_wr_data"},   32'(bus_p.wr_data), 32'd0);
        check_output({tag, "_p_busy"},      32'(bus_p.busy), 32'd0);
        check_output({tag, "_p_frame_err"}, 32'(bus_p.frame_err), 32'd0);
        check_output({tag, "_n_wr_en"},     32'(bus_n.wr_en), 32'd0);
        check_output({tag, "_n_wr_addr"},   32'(bus_n.wr_addr), 32'd0);
        check_output({tag, "_n_busy"},      32'(bus_n.busy), 32'd0);
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            odd;
        bus_p.bit_valid = 1'b0;
        bus_p.data      = 1'b0;
        bus_n.bit_valid = 1'b0;
        bus_n.data      = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] directed frames");
        apply_stimulus(0, 3'd5, 8'hA5, 1'b0, 1'b0);
        apply_stimulus(0, 3'd1, 8'h01, 1'b1, 1'b0);
        apply_stimulus(0, 3'd7, 8'h3C, 1'b1, 1'b1);

        $display("[TB] abort mid-frame");
        drive_cycle(0, 1'b1, 1'b1);
        drive_cycle(0, 1'b1, 1'b0);
        drive_cycle(0, 1'b1, 1'b1);
        drive_cycle(0, 1'b1, 1'b1);
        drive_cycle(0, 1'b1, 1'b0);
        drive_cycle(0, 1'b1, 1'b1);
        check_output("busy_mid_frame", 32'(bus_p.busy), 32'd1);
        rst = 1'b0;
        bus_p.bit_valid = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_hold");
        rst = 1'b1;
        @(negedge clk);
        apply_stimulus(0, 3'd2, 8'hFF, 1'b1, 1'b0);

        $display("[TB] parity-free instance");
        apply_stimulus(1, 3'd0, 8'h00, 1'b0, 1'b0);

        $display("[TB] random frames");
        for (int k = 0; k < 100; k++) begin
            a   = 3'($urandom_range(0, 7));
            d   = 8'($urandom_range(0, 255));
            odd = ($countones({a, d}) % 2) == 1;
            apply_stimulus(0, a, d, odd ^ ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        end
        for (int k = 0; k < 100; k++) begin
            a = 3'($urandom_range(0, 7));
            d = 8'($urandom_range(0, 255));
            apply_stimulus(1, a, d, 1'b0, 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        check_output("queue_p_drained", 32'(exp_p.size()), 32'd0);
        check_output("queue_n_drained", 32'(exp_n.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
